arb_client_mux: RTL and testbench

- Requester-side companion to the 4-way round-robin arbiter.
- Collects valid/ready streams from 4 clients and drives the arbiter's `request` vector.
- Consumes the arbiter's `grant`/`index`, then forwards the winning client's burst onto one shared valid/ready output.
- Releases the request when the burst ends, so the arbiter can rotate to the next client.

---
 rtl/arb_client_mux.sv | 121 ++++++++++++
 tb/tb_arb_client_mux.sv | 304 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/arb_client_mux.sv
// Requester-side front end for a 4-way round-robin arbiter: collects client streams, forwards the winner's burst.
// Optional build macro ARB_CHECK_EN adds a sticky arb_err output flagging malformed or unstable grants.
module arb_client_mux #(
    parameter int DATA_W    = 8,
    parameter int BURST_MAX = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [3:0]          cli_valid,
    input  logic [4*DATA_W-1:0] cli_data,
    input  logic [3:0]          cli_last,
    output logic [3:0]          cli_ready,
    output logic [3:0]          arb_request,
    input  logic [3:0]          arb_grant,
    input  logic [1:0]          arb_index,
    output logic                out_valid,
    output logic [DATA_W-1:0]   out_data,
    output logic                out_last,
    output logic [1:0]          out_src,
`ifdef ARB_CHECK_EN
    output logic                arb_err,
`endif
    input  logic                out_ready
);

    localparam int CNT_W = $clog2(BURST_MAX + 1);
    localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BURST_MAX - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        XFER = 2'd2,
        REL  = 2'd3
    } state_t;

    state_t           state;
    logic [1:0]       owner;
    logic [CNT_W-1:0] beat_cnt;

    logic [3:0] owner_mask;
    logic [3:0] index_mask;
    logic       grant_onehot;
    logic       grant_wellformed;
    logic       grant_ok;
    logic       beat_fire;

    assign owner_mask       = 4'b0001 << owner;
    assign index_mask       = 4'b0001 << arb_index;
    assign grant_onehot     = (arb_grant != 4'b0000) && ((arb_grant & (arb_grant - 4'd1)) == 4'b0000);
    assign grant_wellformed = grant_onehot && (arb_grant == index_mask);
    assign grant_ok         = grant_wellformed && cli_valid[arb_index];
    assign beat_fire        = out_valid && out_ready;

    // Outputs are decoded straight from state/owner so a reset cycle presents a quiet interface.
    always_comb begin
        cli_ready   = 4'b0000;
        arb_request = 4'b0000;
        out_valid   = 1'b0;
        out_data    = '0;
        out_last    = 1'b0;
        out_src     = 2'd0;
        if (!rst) begin
            case (state)
                REQ: arb_request = cli_valid;
                XFER: begin
                    arb_request = owner_mask;
                    out_valid   = cli_valid[owner];
                    out_data    = cli_data[int'(owner)*DATA_W +: DATA_W];
                    out_last    = cli_last[owner] || (beat_cnt == LAST_BEAT);
                    out_src     = owner;
                    cli_ready   = owner_mask & {4{out_ready}};
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            owner    <= 2'd0;
            beat_cnt <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (cli_valid != 4'b0000) state <= REQ;
                end
                REQ: begin
                    if (grant_ok) begin
                        owner    <= arb_index;
                        beat_cnt <= '0;
                        state    <= XFER;
                    end else if (cli_valid == 4'b0000) begin
                        state <= IDLE;
                    end
                end
                XFER: begin
                    // A forced out_last ends the tenure; the rest of the packet re-arbitrates.
                    if (beat_fire) begin
                        if (out_last) state <= REL;
                        else          beat_cnt <= beat_cnt + CNT_W'(1);
                    end
                end
                REL:     state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

`ifdef ARB_CHECK_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            arb_err <= 1'b0;
        end else if ((state == REQ && arb_grant != 4'b0000 && !grant_wellformed) ||
                     (state == XFER && arb_grant != owner_mask)) begin
            arb_err <= 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_arb_client_mux.sv
// Bench for arb_client_mux: plays the four clients, a round-robin arbiter and the sink,
// and checks every cycle against a tenure-level model plus directed literal traces.
`timescale 1ns/1ps
module tb_arb_client_mux;

    localparam int DATA_W    = 8;
    localparam int BURST_MAX = 4;

    logic                clk = 1'b0;
    logic                rst;
    logic [3:0]          cli_valid;
    logic [4*DATA_W-1:0] cli_data;
    logic [3:0]          cli_last;
    logic [3:0]          cli_ready;
    logic [3:0]          arb_request;
    logic [3:0]          arb_grant;
    logic [1:0]          arb_index;
    logic                out_valid;
    logic [DATA_W-1:0]   out_data;
    logic                out_last;
    logic [1:0]          out_src;
    logic                out_ready;
`ifdef ARB_CHECK_EN
    logic                arb_err;
    bit                  m_err;
`endif

    arb_client_mux #(.DATA_W(DATA_W), .BURST_MAX(BURST_MAX)) dut (
        .clk         (clk),
        .rst         (rst),
        .cli_valid   (cli_valid),
        .cli_data    (cli_data),
        .cli_last    (cli_last),
        .cli_ready   (cli_ready),
        .arb_request (arb_request),
        .arb_grant   (arb_grant),
        .arb_index   (arb_index),
        .out_valid   (out_valid),
        .out_data    (out_data),
        .out_last    (out_last),
        .out_src     (out_src),
`ifdef ARB_CHECK_EN
        .arb_err     (arb_err),
`endif
        .out_ready   (out_ready)
    );

    always #5 clk = ~clk;

    // Per-client pending beats {last, data}; the head is what the client presents.
    logic [8:0]  cq [4][$];
    // Accepted beats {src, last, data} in acceptance order.
    logic [10:0] log_q [$];
    logic [3:0]  bad_grants [6] = '{4'b0011, 4'b0110, 4'b1100, 4'b1001, 4'b1111, 4'b0101};

    int         m_owner = -1;
    bit         m_cool  = 1'b0;
    bit         m_want  = 1'b0;
    int         m_beats = 0;
    logic [3:0] m_req   = 4'b0000;
    int         arb_cur  = -1;
    int         arb_last = 3;
    bit         random_mode = 1'b0;
    bit         force_bad   = 1'b0;
    int         n_checks = 0;
    int         n_fail   = 0;
    int         cycle    = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s @cycle %0d: got %0h, expected %0h", name, cycle, act, exp);
        end
    endtask

    task automatic applyStimulus(input bit do_rst);
        bit have;
        int k;
        rst = do_rst;
        for (int i = 0; i < 4; i++) begin
            have = cq[i].size() != 0;
            cli_valid[i] = have && (!random_mode || $urandom_range(0, 9) < 8);
            cli_data[i*DATA_W +: DATA_W] = have ? cq[i][0][7:0] : 8'h00;
            cli_last[i] = have ? cq[i][0][8] : 1'b0;
        end
        out_ready = random_mode ? ($urandom_range(0, 9) < 7) : 1'b1;
        if (arb_cur >= 0) begin
            arb_grant = 4'b0001 << arb_cur;
            arb_index = 2'(arb_cur);
        end else begin
            arb_grant = 4'b0000;
            arb_index = 2'($urandom_range(0, 3));
        end
        if (force_bad) begin
            arb_grant = 4'b0110;
            arb_index = 2'd1;
        end else if (random_mode && $urandom_range(0, 11) == 0) begin
            if ($urandom_range(0, 1) == 1) begin
                arb_grant = bad_grants[$urandom_range(0, 5)];
            end else begin
                k = $urandom_range(0, 3);
                arb_grant = 4'b0001 << k;
                arb_index = 2'((k + 1) % 4);
            end
        end
    endtask

    task automatic checkOutput();
        logic [3:0] e_req, e_rdy;
        logic       e_val, e_last;
        logic [1:0] e_src;
        logic [7:0] e_data;
        bit         xfer;
        e_req = 4'b0000; e_rdy = 4'b0000; e_val = 1'b0; e_last = 1'b0;
        e_src = 2'd0;    e_data = 8'h00;
        xfer = !rst && (m_owner >= 0);
        if (!rst) begin
            if (m_owner >= 0) begin
                e_req  = 4'b0001 << m_owner;
                e_val  = cli_valid[m_owner];
                e_rdy  = out_ready ? e_req : 4'b0000;
                e_data = (cq[m_owner].size() != 0) ? cq[m_owner][0][7:0] : 8'h00;
                e_last = ((cq[m_owner].size() != 0) && cq[m_owner][0][8]) || (m_beats == BURST_MAX - 1);
                e_src  = 2'(m_owner);
            end else if (!m_cool && m_want) begin
                e_req = cli_valid;
            end
        end
        m_req = e_req;
        check("arb_request", 32'(arb_request), 32'(e_req));
        check("cli_ready",   32'(cli_ready),   32'(e_rdy));
        check("out_valid",   32'(out_valid),   32'(e_val));
        if (rst || xfer) begin
            check("out_src",  32'(out_src),  32'(e_src));
            check("out_last", 32'(out_last), 32'(e_last));
            check("out_data", 32'(out_data), 32'(e_data));
        end
`ifdef ARB_CHECK_EN
        check("arb_err", 32'(arb_err), 32'(m_err));
`endif
    endtask

    task automatic updateModel();
        bit lst, good;
        int c;
        if (rst) begin
            m_owner = -1; m_cool = 1'b0; m_want = 1'b0; m_beats = 0;
            arb_cur = -1; arb_last = 3;
`ifdef ARB_CHECK_EN
            m_err = 1'b0;
`endif
        end else begin
            if (m_owner >= 0) begin
`ifdef ARB_CHECK_EN
                if (arb_grant != (4'b0001 << m_owner)) m_err = 1'b1;
`endif
                if (cli_valid[m_owner] && out_ready) begin
                    lst = cq[m_owner][0][8] || (m_beats == BURST_MAX - 1);
                    log_q.push_back({2'(m_owner), lst, cq[m_owner][0][7:0]});
                    void'(cq[m_owner].pop_front());
                    if (lst) begin
                        m_owner = -1; m_cool = 1'b1; m_beats = 0;
                    end else begin
                        m_beats++;
                    end
                end
            end else if (m_cool) begin
                m_cool = 1'b0;
            end else if (m_want) begin
                good = $onehot(arb_grant) && (arb_grant == (4'b0001 << arb_index));
`ifdef ARB_CHECK_EN
                if (arb_grant != 4'b0000 && !good) m_err = 1'b1;
`endif
                if (good && cli_valid[arb_index]) begin
                    m_owner = int'(arb_index); m_beats = 0; m_want = 1'b0;
                end else if (cli_valid == 4'b0000) begin
                    m_want = 1'b0;
                end
            end else if (cli_valid != 4'b0000) begin
                m_want = 1'b1;
            end
            // Round-robin arbiter: hold a grant while its request stays up, else rotate.
            if (!(arb_cur >= 0 && m_req[arb_cur])) begin
                arb_cur = -1;
                for (int k = 1; k <= 4; k++) begin
                    c = (arb_last + k) % 4;
                    if (arb_cur < 0 && m_req[c]) begin
                        arb_cur = c; arb_last = c;
                    end
                end
            end
        end
    endtask

    task automatic step(input bit do_rst);
        applyStimulus(do_rst);
        @(negedge clk);
        checkOutput();
        updateModel();
        @(posedge clk);
        #1;
        cycle++;
    endtask

    function automatic int pending();
        return cq[0].size() + cq[1].size() + cq[2].size() + cq[3].size();
    endfunction

    task automatic runUntilDrained(input string name, input int budget);
        int n;
        n = 0;
        while (pending() != 0 && n < budget) begin
            step(1'b0);
            n++;
        end
        check({name, "_drained"}, 32'(pending()), 32'd0);
        repeat (3) step(1'b0);
    endtask

    task automatic checkLog(input string name, input logic [10:0] exp [], input int n);
        check({name, "_count"}, 32'(log_q.size()), 32'(n));
        for (int i = 0; i < n; i++) begin
            if (i < log_q.size()) check({name, "_beat"}, 32'(log_q[i]), 32'(exp[i]));
        end
    endtask

    initial begin
        logic [10:0] exp_single [] = '{11'h0A1, 11'h0A2, 11'h1A3};
        logic [10:0] exp_rot    [] = '{11'h1C0, 11'h5C2, 11'h7C3};
        logic [10:0] exp_trunc  [] = '{11'h210, 11'h211, 11'h212, 11'h313, 11'h214, 11'h315};
        int len;

        rst = 1'b1; cli_valid = 4'b1111; cli_data = '0; cli_last = 4'b0000;
        out_ready = 1'b0; arb_grant = 4'b0000; arb_index = 2'd0;
        repeat (2) begin
            @(negedge clk);
            check("rst_arb_request", 32'(arb_request), 32'd0);
            check("rst_cli_ready",   32'(cli_ready),   32'd0);
            check("rst_out_valid",   32'(out_valid),   32'd0);
        end
        rst = 1'b0;
        #1;
        check("idle_arb_request", 32'(arb_request), 32'd0);
        @(negedge clk);
        check("req_arb_request", 32'(arb_request), 32'hF);
        @(posedge clk);
        #1;

        $display("[TB] directed: single client burst");
        step(1'b1);
        log_q.delete();
        cq[0].push_back(9'h0A1); cq[0].push_back(9'h0A2); cq[0].push_back(9'h1A3);
        runUntilDrained("single", 60);
        checkLog("single", exp_single, 3);

        $display("[TB] directed: rotation over clients 0,2,3");
        step(1'b1);
        log_q.delete();
        cq[0].push_back(9'h1C0); cq[2].push_back(9'h1C2); cq[3].push_back(9'h1C3);
        runUntilDrained("rotation", 80);
        checkLog("rotation", exp_rot, 3);

        $display("[TB] directed: truncation of a 6-beat packet");
        step(1'b1);
        log_q.delete();
        for (int b = 0; b < 6; b++) cq[1].push_back({b == 5, 8'(8'h10 + b)});
        runUntilDrained("trunc", 80);
        checkLog("trunc", exp_trunc, 6);

`ifdef ARB_CHECK_EN
        $display("[TB] directed: malformed grant");
        step(1'b1);
        cq[2].push_back(9'h155);
        step(1'b0);
        force_bad = 1'b1;
        step(1'b0);
        force_bad = 1'b0;
        check("err_set", 32'(arb_err), 32'd1);
        runUntilDrained("malformed", 40);
        check("err_sticky", 32'(arb_err), 32'd1);
`endif

        $display("[TB] randomized traffic");
        random_mode = 1'b1;
        step(1'b1);
        log_q.delete();
        for (int t = 0; t < 4000; t++) begin
            for (int i = 0; i < 4; i++) begin
                if (cq[i].size() < 8 && $urandom_range(0, 9) == 0) begin
                    len = $urandom_range(1, 6);
                    for (int b = 0; b < len; b++) cq[i].push_back({b == len - 1, 8'($urandom_range(0, 255))});
                end
            end
            step($urandom_range(0, 699) == 0);
        end
        random_mode = 1'b0;
        runUntilDrained("random", 2000);

        $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_fail);
        $finish;
    end

endmodule
